// File: rtl/sdram_burst_responder.sv
// On-chip stand-in for the SDRAM controller: answers wr/rd burst requests with ack bursts
// backed by a 2^ADDR_W x 16 memory. Define REFRESH_STALL_EN to add periodic refresh stalls.
module sdram_burst_responder #(
  parameter int          ADDR_W      = 10,
  parameter logic [15:0] INIT_CYCLES = 16'd200,
  parameter int          ACK_DLY     = 4,
  parameter int          WR_DATA_LAT = 1,
  parameter int          REF_PERIOD  = 780,
  parameter int          REF_CYCLES  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sdram_wr_req,
  input  logic        sdram_rd_req,
  input  logic [23:0] sys_wraddr,
  input  logic [23:0] sys_rdaddr,
  input  logic [9:0]  sdwr_byte,
  input  logic [9:0]  sdrd_byte,
  input  logic [15:0] sys_data_in,
  output logic        sdram_wr_ack,
  output logic        sdram_rd_ack,
  output logic [15:0] sys_data_out,
  output logic        sdram_init_done
);

`ifdef REFRESH_STALL_EN
  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_WR_LAT, S_WR_BURST, S_RD_LAT, S_RD_BURST, S_DRAIN, S_REFRESH
  } state_e;
`else
  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_WR_LAT, S_WR_BURST, S_RD_LAT, S_RD_BURST, S_DRAIN
  } state_e;
  localparam int unused_ref_params = REF_PERIOD + REF_CYCLES;
`endif

  localparam int          PD       = (WR_DATA_LAT == 0) ? 1 : WR_DATA_LAT;
  localparam logic [15:0] LAT_LOAD = 16'(ACK_DLY - 1);

  state_e              state_q;
  logic [15:0]         tmr_q;
  logic [10:0]         cnt_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                wr_ack_q, rd_ack_q, init_done_q;
  logic [15:0]         data_out_q;
  logic [15:0]         mem [2**ADDR_W];

  logic [PD-1:0]             wp_vld_q, wp_vld_d;
  logic [PD-1:0][ADDR_W-1:0] wp_addr_q, wp_addr_d;
  logic                      wr_en, pipe_empty_nxt;
  logic [ADDR_W-1:0]         wr_addr, addr_nxt;
  logic [10:0]               wr_len, rd_len;

`ifdef REFRESH_STALL_EN
  logic [15:0] ref_cnt_q;
  logic        ref_pend_q;
`endif

  logic unused_addr_bits;
  assign unused_addr_bits = ^{sys_wraddr[23:ADDR_W], sys_rdaddr[23:ADDR_W]};

  assign wr_len   = (sdwr_byte == 10'd0) ? 11'd1024 : {1'b0, sdwr_byte};
  assign rd_len   = (sdrd_byte == 10'd0) ? 11'd1024 : {1'b0, sdrd_byte};
  assign addr_nxt = addr_q + ADDR_W'(1);

  // Write pipeline: slot i holds the address of the ack issued i+1 cycles ago.
  always_comb begin
    wp_vld_d     = '0;
    wp_addr_d    = '0;
    wp_vld_d[0]  = wr_ack_q;
    wp_addr_d[0] = addr_q;
    for (int i = 1; i < PD; i++) begin
      wp_vld_d[i]  = wp_vld_q[i-1];
      wp_addr_d[i] = wp_addr_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_vld_q  <= '0;
      wp_addr_q <= '0;
    end else begin
      wp_vld_q  <= wp_vld_d;
      wp_addr_q <= wp_addr_d;
    end
  end

  assign wr_en          = (WR_DATA_LAT == 0) ? wr_ack_q : wp_vld_q[PD-1];
  assign wr_addr        = (WR_DATA_LAT == 0) ? addr_q   : wp_addr_q[PD-1];
  assign pipe_empty_nxt = (WR_DATA_LAT == 0) ? 1'b1     : ~|wp_vld_d;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= sys_data_in;
  end

  // addr_q always names the word of the current (or next) ack; reads are issued one edge early.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_INIT;
      tmr_q       <= '0;
      cnt_q       <= '0;
      addr_q      <= '0;
      wr_ack_q    <= 1'b0;
      rd_ack_q    <= 1'b0;
      data_out_q  <= '0;
      init_done_q <= 1'b0;
`ifdef REFRESH_STALL_EN
      ref_cnt_q   <= '0;
      ref_pend_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_INIT: begin
          if (tmr_q == INIT_CYCLES - 16'd1) begin
            init_done_q <= 1'b1;
            tmr_q       <= '0;
            state_q     <= S_IDLE;
          end else begin
            tmr_q <= tmr_q + 16'd1;
          end
        end
        S_IDLE: begin
`ifdef REFRESH_STALL_EN
          if (ref_pend_q) begin
            ref_pend_q <= 1'b0;
            tmr_q      <= 16'(REF_CYCLES - 1);
            state_q    <= S_REFRESH;
          end else
`endif
          if (sdram_wr_req) begin
            addr_q <= sys_wraddr[ADDR_W-1:0];
            cnt_q  <= wr_len - 11'd1;
            if (ACK_DLY == 1) begin
              wr_ack_q <= 1'b1;
              state_q  <= S_WR_BURST;
            end else begin
              tmr_q   <= LAT_LOAD;
              state_q <= S_WR_LAT;
            end
          end else if (sdram_rd_req) begin
            addr_q <= sys_rdaddr[ADDR_W-1:0];
            cnt_q  <= rd_len - 11'd1;
            if (ACK_DLY == 1) begin
              rd_ack_q   <= 1'b1;
              data_out_q <= mem[sys_rdaddr[ADDR_W-1:0]];
              state_q    <= S_RD_BURST;
            end else begin
              tmr_q   <= LAT_LOAD;
              state_q <= S_RD_LAT;
            end
          end
        end
        S_WR_LAT: begin
          if (tmr_q == 16'd0) begin
            wr_ack_q <= 1'b1;
            state_q  <= S_WR_BURST;
          end else begin
            tmr_q <= tmr_q - 16'd1;
          end
        end
        S_RD_LAT: begin
          if (tmr_q == 16'd0) begin
            rd_ack_q   <= 1'b1;
            data_out_q <= mem[addr_q];
            state_q    <= S_RD_BURST;
          end else begin
            tmr_q <= tmr_q - 16'd1;
          end
        end
        S_WR_BURST: begin
          if (cnt_q == 11'd0) begin
            wr_ack_q <= 1'b0;
            state_q  <= S_DRAIN;
          end else begin
            cnt_q  <= cnt_q - 11'd1;
            addr_q <= addr_nxt;
          end
        end
        S_RD_BURST: begin
          if (cnt_q == 11'd0) begin
            rd_ack_q <= 1'b0;
            state_q  <= S_DRAIN;
          end else begin
            cnt_q      <= cnt_q - 11'd1;
            addr_q     <= addr_nxt;
            data_out_q <= mem[addr_nxt];
          end
        end
        S_DRAIN: begin
          if (pipe_empty_nxt) state_q <= S_IDLE;
        end
`ifdef REFRESH_STALL_EN
        S_REFRESH: begin
          if (tmr_q == 16'd0) state_q <= S_IDLE;
          else                tmr_q   <= tmr_q - 16'd1;
        end
`endif
        default: state_q <= S_IDLE;
      endcase
`ifdef REFRESH_STALL_EN
      // Placed after the case so a new period due on the clearing edge is not lost.
      if (ref_cnt_q == 16'(REF_PERIOD - 1)) begin
        ref_cnt_q  <= '0;
        ref_pend_q <= 1'b1;
      end else begin
        ref_cnt_q <= ref_cnt_q + 16'd1;
      end
`endif
    end
  end

  assign sdram_wr_ack    = wr_ack_q;
  assign sdram_rd_ack    = rd_ack_q;
  assign sys_data_out    = data_out_q;
  assign sdram_init_done = init_done_q;

endmodule

// File: doc/sdram_burst_responder.md
Name: sdram_burst_responder

Overview:
Behavioural/synthesisable stand-in for the SDRAM controller on the system side of the burst request/ack interface. It answers sdram_wr_req/sdram_rd_req with sdram_wr_ack/sdram_rd_ack bursts and stores data in an on-chip 16-bit memory. R/W test harnesses can use it for bring-up and simulation without external SDRAM. It sits where the SDRAM controller would, on the clk_100m domain.

Parameters:
ADDR_W, 10, memory index width; depth = 2^ADDR_W 16-bit words
INIT_CYCLES, 16'd200, clocks after reset release before sdram_init_done rises
ACK_DLY, 4, cycles from request acceptance to first ack (1..15)
WR_DATA_LAT, 1, cycles between a wr_ack cycle and sampling of its sys_data_in word (0..3)
REF_PERIOD, 780, clocks between refresh stalls (optional feature only)
REF_CYCLES, 8, length of one refresh stall (optional feature only)

Ports:
clk  in  1  system clock (100 MHz)
rst_n  in  1  asynchronous active-low reset
sdram_wr_req  in  1  write burst request, level
sdram_rd_req  in  1  read burst request, level
sys_wraddr  in  24  write start word address; bits [ADDR_W-1:0] used
sys_rdaddr  in  24  read start word address; bits [ADDR_W-1:0] used
sdwr_byte  in  10  write burst length in words; 0 means 1024
sdrd_byte  in  10  read burst length in words; 0 means 1024
sys_data_in  in  16  write data
sdram_wr_ack  out  1  high once per accepted write word
sdram_rd_ack  out  1  high once per returned read word
sys_data_out  out  16  read data, valid in each sdram_rd_ack cycle
sdram_init_done  out  1  high after init countdown, stays high until reset

Behaviour:
- Reset: async, active-low. All outputs 0. FSM goes to INIT, counters cleared, write pipeline flushed. Memory contents are not cleared. Reset mid-burst aborts the burst immediately.
- States: INIT, IDLE, WR_LAT, WR_BURST, RD_LAT, RD_BURST, DRAIN (plus REFRESH with option).
- INIT: count INIT_CYCLES clocks, then set sdram_init_done=1 and go to IDLE. Requests during INIT are ignored.
- IDLE: sample requests. If both are high, write wins. On acceptance, latch start address (low ADDR_W bits) and length (10-bit, 0 -> 1024), then go to WR_LAT or RD_LAT.
- WR_LAT/RD_LAT: wait ACK_DLY-1 cycles, so the first ack is ACK_DLY cycles after the accepting IDLE edge.
- WR_BURST: sdram_wr_ack=1 for exactly len consecutive cycles. Each ack cycle pushes (address, valid) into a WR_DATA_LAT-deep shift pipeline. When a slot exits the pipeline, sys_data_in is written to memory at that address. With WR_DATA_LAT=0, data is sampled in the ack cycle itself.
- RD_BURST: sdram_rd_ack=1 for exactly len consecutive cycles. In the k-th ack cycle, sys_data_out = mem[start+k]. Memory read is prefetched so there is no bubble. sys_data_out holds its last value when ack is low.
- Address arithmetic: start+k mod 2^ADDR_W (wraps within the memory).
- Request deasserted mid-burst: burst still completes its full length. Requests are sampled only in IDLE.
- After the last ack, go to DRAIN. Stay there until the write pipeline is empty (at least 1 cycle), then go to IDLE. There is always at least 1 ack-low cycle between bursts.
- Back-to-back: a request still high in IDLE starts a new burst.
- Read-after-write to the same address returns the newly written data.
- wr_ack and rd_ack are never high in the same cycle.

Optional Feature:
REFRESH_STALL_EN:
- Defined: a free-running counter raises a pending flag every REF_PERIOD clocks. If the flag is set in IDLE, the FSM takes priority over requests, enters REFRESH for REF_CYCLES cycles with both acks low, clears the flag, and returns to IDLE. A refresh falling due mid-burst waits until the burst ends; it is never inserted inside a burst.
- Undefined: no counter, no REFRESH state, requests are served immediately from IDLE.

Test Plan:
- Reset release, INIT_CYCLES=200 -> sdram_init_done rises exactly 200 clocks later; acks stay 0 if req is held high during INIT.
- Write 512 words at sys_wraddr=0x000200, data 0x0000..0x01FF advanced on the cycle after each ack (WR_DATA_LAT=1); then read same address -> exactly 512 rd_ack pulses, first one ACK_DLY cycles after acceptance, data 0x0000..0x01FF with no mismatch.
- wr_req and rd_req asserted in the same cycle -> write burst served first; the read starts after DRAIN with at least 1 ack-low cycle between bursts.
- sdwr_byte=0 at address 0x3FF with ADDR_W=10 -> 1024 wr_ack pulses; addresses wrap 0x3FF -> 0x000; read-back matches.
- rst_n pulsed low mid read burst (word 100 of 512) -> acks drop immediately, init_done=0, re-init, then a new request is served normally.
- REFRESH_STALL_EN, REF_PERIOD=780, continuous 512-word bursts -> no refresh inside a burst; an 8-cycle gap with both acks low after the burst during which the refresh fell due.
